// File: rtl/multicore_mem_responder.sv
// Shared single-port word RAM serving NUM_CORES requesters with round-robin arbitration.
// Each accepted request is answered by exactly one rsp_valid pulse two cycles after acceptance.
module multicore_mem_responder #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned ADDR_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    req_valid,
  output logic [NUM_CORES-1:0]    req_ready,
  input  logic [NUM_CORES-1:0]    req_we,
  input  logic [32*NUM_CORES-1:0] req_addr,
  input  logic [32*NUM_CORES-1:0] req_wdata,
  input  logic [4*NUM_CORES-1:0]  req_be,
  output logic [NUM_CORES-1:0]    rsp_valid,
  output logic [31:0]             rsp_rdata,
  output logic                    busy
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, ACCEPTED, RESP} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   grant_q, rr_last_q, win_idx;
  logic               win_found;
  logic               take;
  logic               we_q, sel_we;
  logic [ADDR_W-1:0]  idx_q, sel_idx;
  logic [31:0]        wdata_q, sel_wdata;
  logic [3:0]         be_q, sel_be;
  logic [31:0]        mem [DEPTH];

  // Byte-offset and high address bits are deliberately ignored (addresses alias).
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr;

  // Round-robin winner: first valid core after the last granted one, wrapping.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = 32'(rr_last_q) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!win_found && req_valid[IDX_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  // Payload of the winning core.
  always_comb begin
    sel_we    = 1'b0;
    sel_idx   = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (win_idx == IDX_W'(i)) begin
        sel_we    = req_we[i];
        sel_idx   = req_addr[32*i+2 +: ADDR_W];
        sel_wdata = req_wdata[32*i +: 32];
        sel_be    = req_be[4*i +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    take      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          req_ready[win_idx] = 1'b1;
          take               = 1'b1;
          state_d            = ACCEPTED;
        end
      end
      ACCEPTED: state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_last_q <= IDX_W'(NUM_CORES - 1);
      we_q      <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy      <= (state_d != IDLE);
      rsp_valid <= '0;
      rsp_rdata <= '0;
      if (take) begin
        grant_q   <= win_idx;
        rr_last_q <= win_idx;
        we_q      <= sel_we;
        idx_q     <= sel_idx;
        wdata_q   <= sel_wdata;
        be_q      <= sel_be;
      end
      if (state_q == ACCEPTED) begin
        rsp_valid[grant_q] <= 1'b1;
        rsp_rdata          <= we_q ? 32'h0 : mem[idx_q];
      end
    end
  end

  // RAM is not reset; writes commit only on the ACCEPTED edge.
  always_ff @(posedge clk) begin
    if (state_q == ACCEPTED && we_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_multicore_mem_responder.sv
// Self-checking bench for multicore_mem_responder: vector table, directed corner cases
// and randomized traffic against a transaction-level reference model.
module tb_multicore_mem_responder;

  localparam int NC = 4;
  localparam int AW = 10;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NC-1:0]     req_valid = '0;
  logic [NC-1:0]     req_ready;
  logic [NC-1:0]     req_we = '0;
  logic [32*NC-1:0]  req_addr = '0;
  logic [32*NC-1:0]  req_wdata = '0;
  logic [4*NC-1:0]   req_be = '0;
  logic [NC-1:0]     rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              busy;

  multicore_mem_responder #(.NUM_CORES(NC), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    bit          chk;
  } req_t;

  typedef struct {
    int   core;
    req_t r;
  } vec_t;

  // Reference model: pending requests per core, memory image, transaction in flight.
  req_t        q [NC][$];
  logic [31:0] mmem [int];
  int          ph;        // cycles since acceptance, 0 = free
  int          rr;
  int          cur_core;
  req_t        cur;
  logic [31:0] cur_data;
  bit          cur_unk;
  int          cyc;
  int          dut_grant[$];
  int          acc_cyc[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int pick();
    for (int k = 1; k <= NC; k++) begin
      int c;
      c = (rr + k) % NC;
      if (q[c].size() > 0) return c;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NC; i++) if (q[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_clear();
    ph = 0;
    rr = NC - 1;
    for (int i = 0; i < NC; i++) q[i].delete();
  endtask

  // One clock cycle: drive queue heads, compare outputs, advance the model.
  task automatic step();
    int          w;
    int          widx;
    logic [31:0] word;
    for (int i = 0; i < NC; i++) begin
      if (q[i].size() > 0) begin
        req_valid[i]            = 1'b1;
        req_we[i]               = q[i][0].we;
        req_addr[32*i +: 32]    = q[i][0].addr;
        req_wdata[32*i +: 32]   = q[i][0].wdata;
        req_be[4*i +: 4]        = q[i][0].be;
      end else begin
        req_valid[i]            = 1'b0;
        req_we[i]               = 1'($urandom);
        req_addr[32*i +: 32]    = $urandom;
        req_wdata[32*i +: 32]   = $urandom;
        req_be[4*i +: 4]        = 4'($urandom);
      end
    end
    #1;
    w = (ph == 0) ? pick() : -1;
    chk("req_ready", 32'(req_ready), (w >= 0) ? (32'd1 << w) : 32'd0);
    chk("busy", 32'(busy), 32'(ph != 0));
    chk("rsp_valid", 32'(rsp_valid), (ph == 2) ? (32'd1 << cur_core) : 32'd0);
    if (ph == 2) begin
      if (!cur_unk) chk("rsp_rdata_model", rsp_rdata, cur_data);
      if (cur.chk) chk("rsp_rdata_vector", rsp_rdata, cur.exp);
    end else begin
      chk("rsp_rdata_idle", rsp_rdata, 32'h0);
    end
    if (req_ready != '0) begin
      dut_grant.push_back($clog2(req_ready));
      acc_cyc.push_back(cyc);
    end
    if (ph == 0 && w >= 0) begin
      cur      = q[w].pop_front();
      cur_core = w;
      rr       = w;
      widx     = int'((cur.addr >> 2) % (32'd1 << AW));
      word     = mmem.exists(widx) ? mmem[widx] : 32'hx;
      if (cur.we) begin
        for (int b = 0; b < 4; b++) if (cur.be[b]) word[8*b +: 8] = cur.wdata[8*b +: 8];
        mmem[widx] = word;
        cur_data   = 32'h0;
        cur_unk    = 1'b0;
      end else begin
        cur_data = word;
        cur_unk  = $isunknown(word);
      end
      ph = 1;
    end else if (ph == 1) begin
      ph = 2;
    end else if (ph == 2) begin
      ph = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while ((pending() || ph != 0) && n < maxc) begin
      step();
      n++;
    end
    chk("drain_within_budget", 32'(n < maxc), 32'd1);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_req_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rsp_rdata", rsp_rdata, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    dut_grant.delete();
    acc_cyc.delete();
  endtask

  function automatic req_t mk(bit we, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, logic [31:0] exp, bit c);
    req_t r;
    r.we = we; r.addr = addr; r.wdata = wdata; r.be = be; r.exp = exp; r.chk = c;
    return r;
  endfunction

  initial begin
    vec_t vecs[10];
    int   exp_rr[8];
    int   exp_ct[6];
    int   n;

    cyc = 0;
    vecs[0] = '{2, mk(1'b1, 32'h0000_0040, 32'hDEADBEEF, 4'hF, 32'h0,        1'b1)};
    vecs[1] = '{2, mk(1'b0, 32'h0000_0040, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1)};
    vecs[2] = '{1, mk(1'b1, 32'h0000_0080, 32'h11223344, 4'hF, 32'h0,        1'b1)};
    vecs[3] = '{0, mk(1'b1, 32'h0000_0080, 32'hAABBCCDD, 4'h5, 32'h0,        1'b1)};
    vecs[4] = '{3, mk(1'b0, 32'h0000_0080, 32'h0,        4'h0, 32'h11BB33DD, 1'b1)};
    vecs[5] = '{0, mk(1'b1, 32'h0000_1000, 32'hCAFEF00D, 4'hF, 32'h0,        1'b1)};
    vecs[6] = '{1, mk(1'b0, 32'h0000_0000, 32'h0,        4'h0, 32'hCAFEF00D, 1'b1)};
    vecs[7] = '{2, mk(1'b0, 32'h0000_0003, 32'h0,        4'h0, 32'hCAFEF00D, 1'b1)};
    vecs[8] = '{3, mk(1'b1, 32'h0000_0040, 32'h12345678, 4'h0, 32'h0,        1'b1)};
    vecs[9] = '{0, mk(1'b0, 32'h0000_0040, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1)};
    exp_rr = '{0, 1, 2, 3, 0, 1, 2, 3};
    exp_ct = '{0, 3, 0, 3, 0, 3};

    // Vector table: one transaction at a time.
    do_reset();
    for (int v = 0; v < 10; v++) begin
      q[vecs[v].core].push_back(vecs[v].r);
      run(20);
    end

    // All cores requesting continuously from reset.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++)
        q[c].push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1));
    run(60);
    chk("rr_grant_count", 32'(dut_grant.size()), 32'd8);
    n = (dut_grant.size() < 8) ? dut_grant.size() : 8;
    for (int i = 0; i < n; i++) chk("rr_grant_order", 32'(dut_grant[i]), 32'(exp_rr[i]));
    for (int i = 1; i < n; i++) chk("rr_accept_spacing", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd3);

    // Cores 0 and 3 contending.
    do_reset();
    for (int r = 0; r < 3; r++) begin
      q[0].push_back(mk(1'b0, 32'h80, 32'h0, 4'h0, 32'h11BB33DD, 1'b1));
      q[3].push_back(mk(1'b1, 32'h100, 32'($urandom), 4'hF, 32'h0, 1'b1));
    end
    run(60);
    chk("ct_grant_count", 32'(dut_grant.size()), 32'd6);
    n = (dut_grant.size() < 6) ? dut_grant.size() : 6;
    for (int i = 0; i < n; i++) chk("ct_grant_order", 32'(dut_grant[i]), 32'(exp_ct[i]));

    // Reset during RESP of a read abandons the response and restarts priority.
    do_reset();
    q[2].push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1));
    n = 0;
    while (ph != 2 && n < 20) begin
      step();
      n++;
    end
    chk("midop_reached_resp", 32'(ph == 2), 32'd1);
    chk("midop_pre_rsp_valid", 32'(rsp_valid), 32'h4);
    rst_n = 1'b0;
    #1;
    chk("midop_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midop_busy", 32'(busy), 32'h0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    dut_grant.delete();
    acc_cyc.delete();
    q[1].push_back(mk(1'b0, 32'h80, 32'h0, 4'h0, 32'h11BB33DD, 1'b1));
    q[0].push_back(mk(1'b0, 32'h40, 32'h0, 4'h0, 32'hDEADBEEF, 1'b1));
    run(30);
    chk("midop_first_grant", (dut_grant.size() > 0) ? 32'(dut_grant[0]) : 32'hFFFF_FFFF, 32'd0);

    // Randomized traffic on a small aliased window.
    do_reset();
    for (int w = 0; w < 16; w++)
      q[$urandom_range(0, NC-1)].push_back(
        mk(1'b1, 32'(w) << 2, $urandom, 4'hF, 32'h0, 1'b0));
    run(200);
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 9) < 4) begin
        int   c;
        req_t r;
        c = $urandom_range(0, NC-1);
        r = mk(1'($urandom), ($urandom & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2),
               $urandom, 4'($urandom), 32'h0, 1'b0);
        if (q[c].size() < 3 && !(q[c].size() == 0 && ph == 0)) q[c].push_back(r);
        else if (q[c].size() < 3 && ph != 0) q[c].push_back(r);
      end
      step();
    end
    run(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
